// File: rtl/multi_signal_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multi_signal_timer_pkg
// Purpose : Shared types and default constants for the multi-channel
//           qualified-timeout detector (per-channel FSM state encoding and
//           the default channel count / delay width / trigger level).
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package multi_signal_timer_pkg;

    // Per-channel timer state. Encoding is fixed so that state values seen
    // in waveforms are stable across builds.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,   // waiting for sig to reach the trigger level
        ST_COUNT = 2'b01,   // qualifying: counting clocks up to the latched delay
        ST_FIRED = 2'b10    // timeout reached, qualified level asserted
    } state_t;

    // Default configuration shared by the top level and its bus interface.
    localparam int   c_DEF_NCH        = 4;     // number of independent channels
    localparam int   c_DEF_CW         = 4;     // delay / counter width
    localparam logic c_DEF_TRIG_LEVEL = 1'b0;  // sig value that arms a channel

endpackage : multi_signal_timer_pkg
`default_nettype wire

// File: rtl/multi_signal_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : multi_signal_timer_if
// Purpose : Bus bundle between the condition sources / consumer FSMs and the
//           multi-channel timer.
// Signals : enable      [NCH]  per-channel enable (master -> timer)
//           sig         [NCH]  monitored condition lines (master -> timer)
//           delay       [CW]   shared terminal count (master -> timer)
//           clear_flags [NCH]  sticky-flag clear strobes (master -> timer)
//           signal_out  [NCH]  qualified level outputs (timer -> master)
//           fire_pulse  [NCH]  one-cycle firing strobes (timer -> master)
//           busy        [NCH]  channel is counting (timer -> master)
//           fired_flags [NCH]  sticky fired status (timer -> master)
// Revision: 1.0  initial release
// ============================================================================
interface multi_signal_timer_if
    import multi_signal_timer_pkg::*;
#(
    parameter int NCH = c_DEF_NCH,
    parameter int CW  = c_DEF_CW
) ();

    logic [NCH-1:0] enable;
    logic [NCH-1:0] sig;
    logic [CW-1:0]  delay;
    logic [NCH-1:0] clear_flags;
    logic [NCH-1:0] signal_out;
    logic [NCH-1:0] fire_pulse;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] fired_flags;

    // Side that drives the conditions and consumes the qualified results.
    modport master (
        output enable,
        output sig,
        output delay,
        output clear_flags,
        input  signal_out,
        input  fire_pulse,
        input  busy,
        input  fired_flags
    );

    // The timer itself.
    modport slave (
        input  enable,
        input  sig,
        input  delay,
        input  clear_flags,
        output signal_out,
        output fire_pulse,
        output busy,
        output fired_flags
    );

endinterface : multi_signal_timer_if
`default_nettype wire

// File: rtl/multi_signal_timer_channel.sv
`default_nettype none
// ============================================================================
// Module  : signal_timer_channel
// Purpose : One qualified-timeout channel. Arms when i_sig reaches the
//           trigger level, counts the latched delay, then asserts a level
//           output, a one-cycle fire strobe and a sticky fired flag.
// Ports   : clock          clock, all logic on the rising edge
//           reset          asynchronous active-low reset
//           i_enable       channel enable; low returns the channel to idle
//           i_sig          monitored condition (already synchronous)
//           i_delay        terminal count, captured on entry to counting
//           i_clear_flag   clear strobe for the sticky fired flag
//           o_signal_out   qualified level
//           o_fire_pulse   one-cycle strobe per firing event
//           o_busy         high while counting
//           o_fired_flag   sticky fired status
// Revision: 1.0  initial release
// ============================================================================
module signal_timer_channel
    import multi_signal_timer_pkg::*;
#(
    parameter int   CW         = c_DEF_CW,
    parameter logic TRIG_LEVEL = c_DEF_TRIG_LEVEL,
    parameter bit   ABORT_EN   = 1'b1,
    parameter bit   AUTO_REARM = 1'b0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          i_enable,
    input  wire logic          i_sig,
    input  wire logic [CW-1:0] i_delay,
    input  wire logic          i_clear_flag,
    output logic               o_signal_out,
    output logic               o_fire_pulse,
    output logic               o_busy,
    output logic               o_fired_flag
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   r_dly;
    logic [CW-1:0]   w_dly_nxt;
    logic            r_out;
    logic            w_out_nxt;
    logic            r_pulse;
    logic            w_pulse_nxt;
    logic            r_flag;
    logic            w_flag_nxt;
    logic            w_trig;

    assign w_trig = (i_sig == TRIG_LEVEL);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_dly   <= '0;
            r_out   <= 1'b0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_dly   <= w_dly_nxt;
            r_out   <= w_out_nxt;
            r_pulse <= w_pulse_nxt;
            r_flag  <= w_flag_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_dly_nxt   = r_dly;
        w_out_nxt   = r_out;
        w_pulse_nxt = 1'b0;

        if (!i_enable) begin
            // Disable overrides everything except the sticky flag.
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_out_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_out_nxt = 1'b0;
                    if (w_trig) begin
                        w_state_nxt = ST_COUNT;
                        w_count_nxt = '0;
                        w_dly_nxt   = i_delay;
                    end
                end

                ST_COUNT: begin
                    // Abort is tested before the terminal count so a run
                    // that loses its condition on the last cycle never fires.
                    if (ABORT_EN && !w_trig) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_out_nxt   = 1'b0;
                    end else if (r_count == r_dly) begin
                        // Terminal check precedes the increment, so the
                        // counter tops out at r_dly and never wraps.
                        w_state_nxt = ST_FIRED;
                        w_out_nxt   = 1'b1;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end

                ST_FIRED: begin
                    if (!w_trig) begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_out_nxt   = 1'b0;
                    end else if (AUTO_REARM) begin
                        // Periodic mode: the level stays high while the
                        // next run counts, giving a pulse every dly+2 clocks.
                        w_state_nxt = ST_COUNT;
                        w_count_nxt = '0;
                        w_dly_nxt   = i_delay;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_out_nxt   = 1'b0;
                end
            endcase
        end

        // A firing in the same cycle as a clear leaves the flag set.
        w_flag_nxt = w_pulse_nxt | (r_flag & ~i_clear_flag);
    end

    assign o_signal_out = r_out;
    assign o_fire_pulse = r_pulse;
    assign o_busy       = (r_state == ST_COUNT);
    assign o_fired_flag = r_flag;

endmodule : signal_timer_channel
`default_nettype wire

// File: rtl/multi_signal_timer.sv
`default_nettype none
// ============================================================================
// Module  : multi_signal_timer
// Purpose : NCH independent qualified-timeout detectors. Each channel
//           qualifies its own sig line against TRIG_LEVEL for a programmable
//           number of clocks; the shared delay is fanned out to all channels
//           and latched per channel when a run starts.
// Ports   : clock   clock, all logic on the rising edge
//           reset   asynchronous active-low reset
//           bus     multi_signal_timer_if.slave
//                   (enable, sig, delay, clear_flags in;
//                    signal_out, fire_pulse, busy, fired_flags out)
// Revision: 1.0  initial release
// ============================================================================
module multi_signal_timer
    import multi_signal_timer_pkg::*;
#(
    parameter int   NCH        = c_DEF_NCH,
    parameter int   CW         = c_DEF_CW,
    parameter logic TRIG_LEVEL = c_DEF_TRIG_LEVEL,
    parameter bit   ABORT_EN   = 1'b1,
    parameter bit   AUTO_REARM = 1'b0
) (
    input  wire logic           clock,
    input  wire logic           reset,
    multi_signal_timer_if.slave bus
);

    logic [NCH-1:0] w_signal_out;
    logic [NCH-1:0] w_fire_pulse;
    logic [NCH-1:0] w_busy;
    logic [NCH-1:0] w_fired_flags;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            signal_timer_channel #(
                .CW         (CW),
                .TRIG_LEVEL (TRIG_LEVEL),
                .ABORT_EN   (ABORT_EN),
                .AUTO_REARM (AUTO_REARM)
            ) u_channel (
                .clock        (clock),
                .reset        (reset),
                .i_enable     (bus.enable[g]),
                .i_sig        (bus.sig[g]),
                .i_delay      (bus.delay),
                .i_clear_flag (bus.clear_flags[g]),
                .o_signal_out (w_signal_out[g]),
                .o_fire_pulse (w_fire_pulse[g]),
                .o_busy       (w_busy[g]),
                .o_fired_flag (w_fired_flags[g])
            );
        end
    endgenerate

    assign bus.signal_out  = w_signal_out;
    assign bus.fire_pulse  = w_fire_pulse;
    assign bus.busy        = w_busy;
    assign bus.fired_flags = w_fired_flags;

endmodule : multi_signal_timer
`default_nettype wire

// File: tb/tb_multi_signal_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_signal_timer
// Purpose : Self-checking bench. Three timer instances share one stimulus:
//           default (abort on, no rearm), no-abort, and auto-rearm. A
//           timestamp-based reference model pushes expected outputs per edge
//           to a scoreboard queue that is drained on the falling edge.
// Revision: 1.0  initial release
// ============================================================================
module tb_multi_signal_timer;
    import multi_signal_timer_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 4;
    localparam int NDUT = 3;
    // Instance 0 = default, 1 = no abort, 2 = auto-rearm
    localparam bit [NDUT-1:0] c_ABORT = 3'b101;
    localparam bit [NDUT-1:0] c_REARM = 3'b100;
    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_FIRED = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] tb_enable;
    logic [NCH-1:0] tb_sig;
    logic [NCH-1:0] tb_clear;
    logic [CW-1:0]  tb_delay;

    always #5 clock = ~clock;

    multi_signal_timer_if #(.NCH(NCH), .CW(CW)) bus_def   ();
    multi_signal_timer_if #(.NCH(NCH), .CW(CW)) bus_noab  ();
    multi_signal_timer_if #(.NCH(NCH), .CW(CW)) bus_rearm ();

    assign bus_def.enable        = tb_enable;
    assign bus_def.sig           = tb_sig;
    assign bus_def.delay         = tb_delay;
    assign bus_def.clear_flags   = tb_clear;
    assign bus_noab.enable       = tb_enable;
    assign bus_noab.sig          = tb_sig;
    assign bus_noab.delay        = tb_delay;
    assign bus_noab.clear_flags  = tb_clear;
    assign bus_rearm.enable      = tb_enable;
    assign bus_rearm.sig         = tb_sig;
    assign bus_rearm.delay       = tb_delay;
    assign bus_rearm.clear_flags = tb_clear;

    multi_signal_timer #(.NCH(NCH), .CW(CW), .TRIG_LEVEL(1'b0),
                         .ABORT_EN(1'b1), .AUTO_REARM(1'b0))
        u_dut_def   (.clock(clock), .reset(reset), .bus(bus_def));
    multi_signal_timer #(.NCH(NCH), .CW(CW), .TRIG_LEVEL(1'b0),
                         .ABORT_EN(1'b0), .AUTO_REARM(1'b0))
        u_dut_noab  (.clock(clock), .reset(reset), .bus(bus_noab));
    multi_signal_timer #(.NCH(NCH), .CW(CW), .TRIG_LEVEL(1'b0),
                         .ABORT_EN(1'b1), .AUTO_REARM(1'b1))
        u_dut_rearm (.clock(clock), .reset(reset), .bus(bus_rearm));

    logic [NCH-1:0] act_out   [NDUT];
    logic [NCH-1:0] act_pulse [NDUT];
    logic [NCH-1:0] act_busy  [NDUT];
    logic [NCH-1:0] act_flag  [NDUT];

    assign act_out[0]   = bus_def.signal_out;
    assign act_pulse[0] = bus_def.fire_pulse;
    assign act_busy[0]  = bus_def.busy;
    assign act_flag[0]  = bus_def.fired_flags;
    assign act_out[1]   = bus_noab.signal_out;
    assign act_pulse[1] = bus_noab.fire_pulse;
    assign act_busy[1]  = bus_noab.busy;
    assign act_flag[1]  = bus_noab.fired_flags;
    assign act_out[2]   = bus_rearm.signal_out;
    assign act_pulse[2] = bus_rearm.fire_pulse;
    assign act_busy[2]  = bus_rearm.busy;
    assign act_flag[2]  = bus_rearm.fired_flags;

    typedef struct packed {
        logic [NDUT-1:0][NCH-1:0] out;
        logic [NDUT-1:0][NCH-1:0] pulse;
        logic [NDUT-1:0][NCH-1:0] busy;
        logic [NDUT-1:0][NCH-1:0] flag;
        int                       edge_no;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;   // number of the next rising edge to be modelled
    int base     = 0;

    // Reference model: a run is described by its start edge and latched delay.
    int m_state [NDUT][NCH];
    int m_t0    [NDUT][NCH];
    int m_dl    [NDUT][NCH];
    bit m_out   [NDUT][NCH];
    bit m_pulse [NDUT][NCH];
    bit m_flag  [NDUT][NCH];

    // Observed firing history, updated by the monitor.
    int first_fire [NDUT][NCH];
    int last_fire  [NDUT][NCH];
    int n_pulse    [NDUT][NCH];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_pulse[d][c] = 1'b0;
                if (reset == 1'b0) begin
                    m_state[d][c] = M_IDLE;
                    m_out[d][c]   = 1'b0;
                    m_flag[d][c]  = 1'b0;
                end else begin
                    if (tb_enable[c] == 1'b0) begin
                        m_state[d][c] = M_IDLE;
                        m_out[d][c]   = 1'b0;
                    end else begin
                        case (m_state[d][c])
                            M_IDLE: if (tb_sig[c] == 1'b0) begin
                                m_state[d][c] = M_COUNT;
                                m_t0[d][c]    = cyc;
                                m_dl[d][c]    = int'(tb_delay);
                            end
                            M_COUNT: if (c_ABORT[d] && tb_sig[c]) begin
                                m_state[d][c] = M_IDLE;
                                m_out[d][c]   = 1'b0;
                            end else if (cyc == m_t0[d][c] + m_dl[d][c] + 1) begin
                                m_state[d][c] = M_FIRED;
                                m_out[d][c]   = 1'b1;
                                m_pulse[d][c] = 1'b1;
                            end
                            M_FIRED: if (tb_sig[c]) begin
                                m_state[d][c] = M_IDLE;
                                m_out[d][c]   = 1'b0;
                            end else if (c_REARM[d]) begin
                                m_state[d][c] = M_COUNT;
                                m_t0[d][c]    = cyc;
                                m_dl[d][c]    = int'(tb_delay);
                            end
                            default: ;
                        endcase
                    end
                    m_flag[d][c] = m_pulse[d][c] | (m_flag[d][c] & ~tb_clear[c]);
                end
            end
        end
    endtask

    // Model the coming edge, queue its expectation, then advance one cycle.
    task automatic step();
        exp_t e;
        model_edge();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) begin
                e.out[d][c]   = m_out[d][c];
                e.pulse[d][c] = m_pulse[d][c];
                e.busy[d][c]  = (m_state[d][c] == M_COUNT);
                e.flag[d][c]  = m_flag[d][c];
            end
        end
        e.edge_no = cyc;
        sb_q.push_back(e);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        #1;
    endtask

    task automatic clear_history();
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) begin
                first_fire[d][c] = -1;
                last_fire[d][c]  = -1;
                n_pulse[d][c]    = 0;
            end
        end
        base = cyc;
    endtask

    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("signal_out dut%0d edge%0d", d, mon_e.edge_no), 32'(act_out[d]),   32'(mon_e.out[d]));
                check($sformatf("fire_pulse dut%0d edge%0d", d, mon_e.edge_no), 32'(act_pulse[d]), 32'(mon_e.pulse[d]));
                check($sformatf("busy dut%0d edge%0d", d, mon_e.edge_no),       32'(act_busy[d]),  32'(mon_e.busy[d]));
                check($sformatf("fired_flags dut%0d edge%0d", d, mon_e.edge_no), 32'(act_flag[d]), 32'(mon_e.flag[d]));
                for (int c = 0; c < NCH; c++) begin
                    if (act_pulse[d][c] === 1'b1) begin
                        if (first_fire[d][c] < 0) first_fire[d][c] = mon_e.edge_no;
                        last_fire[d][c] = mon_e.edge_no;
                        n_pulse[d][c]++;
                    end
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s signal_out dut%0d", tag, d),  32'(act_out[d]),   32'h0);
            check($sformatf("%s fire_pulse dut%0d", tag, d),  32'(act_pulse[d]), 32'h0);
            check($sformatf("%s busy dut%0d", tag, d),        32'(act_busy[d]),  32'h0);
            check($sformatf("%s fired_flags dut%0d", tag, d), 32'(act_flag[d]),  32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tb_enable = '1;
        tb_sig    = '1;
        tb_clear  = '0;
        tb_delay  = '0;
        clear_history();

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        step();
        reset = 1'b1;

        // Nominal fire on ch0: delay 11, trigger at edge 10 -> fire at 22
        tb_delay = 4'd11;
        clear_history();
        for (int k = 0; k <= 25; k++) begin
            tb_sig[0] = (k >= 10 && k <= 24) ? 1'b0 : 1'b1;
            step();
        end
        check("nominal fire edge ch0", 32'(last_fire[0][0] - base), 32'd22);
        check("nominal pulse count ch0", 32'(n_pulse[0][0]), 32'd1);

        // Abort on ch1: trigger at 0, release at 3
        tb_delay = 4'd5;
        clear_history();
        for (int k = 0; k <= 9; k++) begin
            tb_sig[1] = (k < 3) ? 1'b0 : 1'b1;
            step();
        end
        check("abort no pulse ch1", 32'(n_pulse[0][1]), 32'd0);
        check("no-abort fire edge ch1", 32'(last_fire[1][1] - base), 32'd6);

        // Auto-rearm on ch2: delay 2, held through edge 11
        tb_delay = 4'd2;
        clear_history();
        for (int k = 0; k <= 14; k++) begin
            tb_sig[2] = (k <= 11) ? 1'b0 : 1'b1;
            step();
        end
        check("rearm first fire ch2", 32'(first_fire[2][2] - base), 32'd3);
        check("rearm last fire ch2", 32'(last_fire[2][2] - base), 32'd11);
        check("rearm pulse count ch2", 32'(n_pulse[2][2]), 32'd3);

        // Delay 0 on ch3 -> fire at T+1
        tb_delay = 4'd0;
        clear_history();
        for (int k = 0; k <= 4; k++) begin
            tb_sig[3] = (k <= 2) ? 1'b0 : 1'b1;
            step();
        end
        check("delay0 fire edge ch3", 32'(last_fire[0][3] - base), 32'd1);

        // Delay 15 on ch0, delay changed to 1 mid-run; ch1 starts later with 1
        clear_history();
        for (int k = 0; k <= 19; k++) begin
            tb_delay  = (k == 0) ? 4'd15 : 4'd1;
            tb_sig[0] = (k <= 16) ? 1'b0 : 1'b1;
            tb_sig[1] = (k >= 3 && k <= 6) ? 1'b0 : 1'b1;
            step();
        end
        check("delay15 fire edge ch0", 32'(last_fire[0][0] - base), 32'd16);
        check("delay15 pulse count ch0", 32'(n_pulse[0][0]), 32'd1);
        check("late start fire edge ch1", 32'(last_fire[0][1] - base), 32'd5);

        // Enable drop on ch3 at count 4
        tb_delay = 4'd8;
        clear_history();
        for (int k = 0; k <= 17; k++) begin
            tb_sig[3]    = (k <= 7) ? 1'b0 : 1'b1;
            tb_enable[3] = (k == 5) ? 1'b0 : 1'b1;
            step();
        end
        check("enable drop no pulse ch3", 32'(n_pulse[0][3]), 32'd0);

        // Sticky flags: clear coincides with fire on ch0, then clears next cycle
        tb_delay = 4'd1;
        clear_history();
        for (int k = 0; k <= 5; k++) begin
            tb_clear  = (k == 0) ? 4'hF : ((k == 2 || k == 3) ? 4'b0001 : 4'b0000);
            tb_sig[0] = (k <= 3) ? 1'b0 : 1'b1;
            tb_sig[1] = (k <= 3) ? 1'b0 : 1'b1;
            step();
        end
        tb_clear = '0;
        check("flags after clear", 32'(act_flag[0]), 32'b0010);

        // Reset asserted mid-count on all channels
        tb_delay = 4'd10;
        for (int k = 0; k <= 2; k++) begin
            tb_sig = '0;
            step();
        end
        check("busy before reset", 32'(act_busy[0]), 32'hF);
        reset = 1'b0;
        #1 check_all_zero("reset_mid_count");
        step();
        step();
        tb_sig = '1;
        reset  = 1'b1;
        for (int k = 0; k < 3; k++) step();

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multi_signal_timer
`default_nettype wire
